vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
Shares a single-port synchronous video RAM (4K x 8) between two requesters: the CPU bus interface and the VDG fetch engine. Replaces the dual-port RAM in the MC-10 top level so the design maps onto single-port block RAM. The arbiter uses a fixed-priority scheme with an anti-starvation counter and has a small state machine that sequences each RAM access and returns a one-cycle acknowledge to the winning requester.

Parameters:
AW, 12, RAM address width.
RD_LAT, 1, RAM read latency in clk_sys cycles (1..3) from address registered to ram_q valid.
VDG_MAX_WAIT, 4, consecutive waiting cycles after which the VDG outranks the CPU (1..15).

Ports:
clk_sys  in  1  system clock; all state on rising edge.
reset_n  in  1  asynchronous active-low reset.
cpu_req  in  1  CPU access request, level, held until cpu_ack.
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req.
cpu_addr  in  AW  CPU address; stable while cpu_req.
cpu_din  in  8  CPU write data.
cpu_dout  out  8  CPU read data; valid with cpu_ack, held until next CPU read completes.
cpu_ack  out  1  one-cycle completion pulse.
vdg_req  in  1  VDG fetch request (read only), level.
vdg_addr  in  AW  VDG fetch address.
vdg_dout  out  8  fetched byte; valid with vdg_ack, held until next VDG completion.
vdg_ack  out  1  one-cycle completion pulse.
ram_addr  out  AW  RAM address, registered.
ram_we  out  1  RAM write enable, registered.
ram_din  out  8  RAM write data, registered.
ram_q  in  8  RAM read data.
gnt_vdg  out  1  1 while the current or last access belongs to the VDG (debug/status).

Behaviour:
- Reset (async, reset_n=0): state=IDLE; cpu_ack=vdg_ack=0; ram_we=0; ram_addr=0; ram_din=0; cpu_dout=vdg_dout=0; gnt_vdg=0; wait counter=0. Reset in mid-access abandons the access with no ack. A write that is in progress is cut short with ram_we forced to 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: requests are sampled only here.
  - If no request, stay in IDLE.
  - If only one requester is active, grant it.
  - If both are active, grant the VDG when wait_cnt >= VDG_MAX_WAIT, otherwise grant the CPU.
  - On grant: load ram_addr, ram_we (= cpu_we for the CPU, 0 for the VDG) and ram_din, set gnt_vdg, then go to ISSUE.
- ISSUE: ram_we is high for exactly this one cycle on writes; ram_we clears on exit. A write goes to DONE. A read goes to WAIT with lat_cnt=RD_LAT-1.
- WAIT: decrement lat_cnt. When lat_cnt=0, capture ram_q into cpu_dout or vdg_dout as per gnt_vdg, then go to DONE.
- DONE: the granted ack is 1 for this cycle only. Next state is IDLE. The requester must have req low in the following IDLE cycle; if req is still high there, it is treated as a new request.
- Latency from the IDLE cycle where req is sampled to the ack cycle:
  - read: RD_LAT+2 cycles (3 at default);
  - write: 2 cycles.
- Minimum spacing is one IDLE cycle between accesses.
- wait_cnt (4 bits):
  - increments, saturating at VDG_MAX_WAIT, on each cycle where vdg_req=1 and the VDG is neither granted nor in service;
  - clears on VDG grant;
  - holds when vdg_req=0.
- ram_addr and ram_din hold their last values outside ISSUE. cpu_dout and vdg_dout are never modified by the other requester's access.
- cpu_ack and vdg_ack are never high in the same cycle.

Test Plan:
- Reset: assert reset_n=0 mid-read (state WAIT) -> all outputs 0 immediately. After release, no stale ack and state is IDLE.
- CPU write then read: write 0x5A to 0x123, then read 0x123 -> ram_we high for exactly 1 cycle, cpu_ack 2 cycles after the write request and 3 after the read request, cpu_dout=0x5A.
- VDG read alone: vdg_addr=0x200 holding 0xC3 -> vdg_ack 3 cycles after the request, vdg_dout=0xC3, cpu_dout unchanged.
- Simultaneous requests: both requesters issue repeatedly; the CPU re-requests in every IDLE cycle -> the CPU wins until wait_cnt reaches 4, then the VDG wins. The VDG waits no more than the 4-cycle threshold plus one access.
- Sticky request: CPU holds cpu_req through the IDLE after ack -> a second access is started. No ack overlaps with the VDG ack.
- RD_LAT=3 build: read 0x7FF -> ack 5 cycles after the request and data is correct.

Source files
------------

// File: rtl/vram_arbiter.sv
// Shares one single-port synchronous video RAM between the CPU bus and the VDG fetch
// engine. Fixed CPU priority, with a wait counter that lets a starved VDG win.
module vram_arbiter #(
    parameter int unsigned AW           = 12,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned VDG_MAX_WAIT = 4
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_ack,
    input  logic          vdg_req,
    input  logic [AW-1:0] vdg_addr,
    output logic [7:0]    vdg_dout,
    output logic          vdg_ack,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_din,
    input  logic [7:0]    ram_q,
    output logic          gnt_vdg
);
    localparam int unsigned LW = 2;
    localparam int unsigned WW = 4;
    localparam logic [LW-1:0] LAT_LOAD = LW'(RD_LAT - 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(VDG_MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [LW-1:0] lat_cnt, lat_cnt_d;
    logic [WW-1:0] wait_cnt, wait_cnt_d;
    logic [AW-1:0] ram_addr_d;
    logic          ram_we_d;
    logic [7:0]    ram_din_d;
    logic [7:0]    cpu_dout_d, vdg_dout_d;
    logic          cpu_ack_d, vdg_ack_d;
    logic          gnt_vdg_d;
    logic          pick_vdg;
    logic          vdg_served;

    // VDG wins when it is alone or has waited long enough
    assign pick_vdg   = vdg_req && (!cpu_req || (wait_cnt >= WAIT_MAX));
    // Outside IDLE, gnt_vdg tells whether the access in flight is the VDG's
    assign vdg_served = (state == IDLE) ? pick_vdg : gnt_vdg;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            lat_cnt  <= '0;
            wait_cnt <= '0;
            ram_addr <= '0;
            ram_we   <= 1'b0;
            ram_din  <= '0;
            cpu_dout <= '0;
            vdg_dout <= '0;
            cpu_ack  <= 1'b0;
            vdg_ack  <= 1'b0;
            gnt_vdg  <= 1'b0;
        end else begin
            state    <= state_d;
            lat_cnt  <= lat_cnt_d;
            wait_cnt <= wait_cnt_d;
            ram_addr <= ram_addr_d;
            ram_we   <= ram_we_d;
            ram_din  <= ram_din_d;
            cpu_dout <= cpu_dout_d;
            vdg_dout <= vdg_dout_d;
            cpu_ack  <= cpu_ack_d;
            vdg_ack  <= vdg_ack_d;
            gnt_vdg  <= gnt_vdg_d;
        end
    end

    always_comb begin
        state_d    = state;
        lat_cnt_d  = lat_cnt;
        wait_cnt_d = wait_cnt;
        ram_addr_d = ram_addr;
        ram_we_d   = ram_we;
        ram_din_d  = ram_din;
        cpu_dout_d = cpu_dout;
        vdg_dout_d = vdg_dout;
        cpu_ack_d  = 1'b0;
        vdg_ack_d  = 1'b0;
        gnt_vdg_d  = gnt_vdg;

        unique case (state)
            IDLE: begin
                if (pick_vdg) begin
                    ram_addr_d = vdg_addr;
                    ram_we_d   = 1'b0;
                    gnt_vdg_d  = 1'b1;
                    state_d    = ISSUE;
                end else if (cpu_req) begin
                    ram_addr_d = cpu_addr;
                    ram_we_d   = cpu_we;
                    ram_din_d  = cpu_din;
                    gnt_vdg_d  = 1'b0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                ram_we_d = 1'b0;
                if (ram_we) begin
                    cpu_ack_d = !gnt_vdg;
                    vdg_ack_d = gnt_vdg;
                    state_d   = DONE;
                end else begin
                    lat_cnt_d = LAT_LOAD;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    if (gnt_vdg) begin
                        vdg_dout_d = ram_q;
                        vdg_ack_d  = 1'b1;
                    end else begin
                        cpu_dout_d = ram_q;
                        cpu_ack_d  = 1'b1;
                    end
                    state_d = DONE;
                end else begin
                    lat_cnt_d = lat_cnt - LW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Anti-starvation counter: counts cycles the VDG is left waiting
        if ((state == IDLE) && pick_vdg) begin
            wait_cnt_d = '0;
        end else if (vdg_req && !vdg_served && (wait_cnt < WAIT_MAX)) begin
            wait_cnt_d = wait_cnt + WW'(1);
        end
    end

endmodule
